// File: rtl/adf4351_pkg.sv
// Shared ADF4351 definitions: register addresses, frame size, default
// programming words used by the transmit sequencers, and the encoding of
// the receive-side write-order tracker.
package adf4351_pkg;

  localparam int ADF_WORD_BITS = 32;
  localparam int ADF_NUM_REGS  = 6;

  localparam logic [2:0] ADF_ADDR_R0 = 3'd0;
  localparam logic [2:0] ADF_ADDR_R1 = 3'd1;
  localparam logic [2:0] ADF_ADDR_R2 = 3'd2;
  localparam logic [2:0] ADF_ADDR_R3 = 3'd3;
  localparam logic [2:0] ADF_ADDR_R4 = 3'd4;
  localparam logic [2:0] ADF_ADDR_R5 = 3'd5;

  // Power-up programming words; low three bits carry the register address.
  localparam logic [31:0] ADF_DEF_R0 = 32'h00500000;
  localparam logic [31:0] ADF_DEF_R1 = 32'h0800E1A9;
  localparam logic [31:0] ADF_DEF_R2 = 32'h00004E42;
  localparam logic [31:0] ADF_DEF_R3 = 32'h000004B3;
  localparam logic [31:0] ADF_DEF_R4 = 32'h008C803C;
  localparam logic [31:0] ADF_DEF_R5 = 32'h00400005;

  // Write-order tracker: S_EXPn means register n is the next expected write.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXP4 = 3'd1,
    S_EXP3 = 3'd2,
    S_EXP2 = 3'd3,
    S_EXP1 = 3'd4,
    S_EXP0 = 3'd5
  } seq_state_t;

  // Observability bundle exported by the receiver.
  typedef struct packed {
    seq_state_t  seq_state;
    logic [5:0]  bit_cnt;
    logic        clk_s;
    logic        le_s;
    logic        dout_s;
  } rx_dbg_t;

  // Register address that keeps the sequence going from state s.
  function automatic logic [2:0] seq_expect(input seq_state_t s);
    case (s)
      S_EXP4:  return ADF_ADDR_R4;
      S_EXP3:  return ADF_ADDR_R3;
      S_EXP2:  return ADF_ADDR_R2;
      S_EXP1:  return ADF_ADDR_R1;
      S_EXP0:  return ADF_ADDR_R0;
      default: return ADF_ADDR_R5;
    endcase
  endfunction

  // State reached after the expected write lands in state s.
  function automatic seq_state_t seq_next(input seq_state_t s);
    case (s)
      S_EXP4:  return S_EXP3;
      S_EXP3:  return S_EXP2;
      S_EXP2:  return S_EXP1;
      S_EXP1:  return S_EXP0;
      default: return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/adf4351_spi_rx_if.sv
// ADF4351 3-wire bus plus the receiver's readback and status signals.
// Bus protocol: no valid/ready backpressure exists. D_CLK/D_OUT/D_LE are
// driven freely by the transmitter; WORD_VALID and the error/sequence flags
// are single-cycle pulses that any observer must catch on the cycle they
// are high; WORD_DATA/WORD_ADDR hold the last accepted word until the next.
interface adf4351_spi_rx_if #(
  parameter int WORD_BITS = 32
);
  import adf4351_pkg::*;

  logic                 D_CLK;
  logic                 D_OUT;
  logic                 D_LE;
  logic [2:0]           RD_ADDR;
  logic [WORD_BITS-1:0] RD_DATA;
  logic                 WORD_VALID;
  logic [WORD_BITS-1:0] WORD_DATA;
  logic [2:0]           WORD_ADDR;
  logic                 FRAME_ERR;
  logic                 ADDR_ERR;
  logic                 SEQ_ERR;
  logic                 SEQ_DONE;
  rx_dbg_t              DBG;

  // Transmitter / bench side.
  modport master (
    output D_CLK, D_OUT, D_LE, RD_ADDR,
    input  RD_DATA, WORD_VALID, WORD_DATA, WORD_ADDR,
    input  FRAME_ERR, ADDR_ERR, SEQ_ERR, SEQ_DONE, DBG
  );

  // Receiver side.
  modport slave (
    input  D_CLK, D_OUT, D_LE, RD_ADDR,
    output RD_DATA, WORD_VALID, WORD_DATA, WORD_ADDR,
    output FRAME_ERR, ADDR_ERR, SEQ_ERR, SEQ_DONE, DBG
  );

endinterface

// File: rtl/adf_sync_edge.sv
// Multi-flop synchronizer for one asynchronous bus line with a rising-edge
// detector comparing the last sync stage against one extra delay flop.
module adf_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic din,
  output logic dsync,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   dly;

  // Shift the raw input through the synchronizer and keep one delayed copy.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      chain <= '0;
      dly   <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      dly   <= chain[SYNC_STAGES-1];
    end
  end

  assign dsync = chain[SYNC_STAGES-1];
  assign rise  = dsync & ~dly;

endmodule

// File: rtl/adf4351_spi_rx.sv
// ADF4351 programming-bus receiver: oversamples D_CLK/D_OUT/D_LE, shifts
// 32-bit words MSB first, validates them on LE rise, keeps an R0..R5 shadow
// bank for readback and tracks the 5,4,3,2,1,0 programming order.
module adf4351_spi_rx
  import adf4351_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WORD_BITS   = ADF_WORD_BITS,
  parameter int NUM_REGS    = ADF_NUM_REGS
) (
  input  logic            CLK,
  input  logic            RST,
  adf4351_spi_rx_if.slave bus
);

  logic                   clk_sync;
  logic                   clk_rise;
  logic                   le_sync;
  logic                   le_rise;
  logic [SYNC_STAGES-1:0] dout_chain;
  logic                   dout_sync;

  logic [WORD_BITS-1:0]   shreg;
  logic [5:0]             bit_cnt;
  logic [WORD_BITS-1:0]   bank [NUM_REGS];
  seq_state_t             seq_state;

  logic [2:0]             frame_addr;
  logic                   frame_full;
  logic                   addr_ok;
  logic                   accept;

  adf_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .CLK   (CLK),
    .RST   (RST),
    .din   (bus.D_CLK),
    .dsync (clk_sync),
    .rise  (clk_rise)
  );

  adf_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_le (
    .CLK   (CLK),
    .RST   (RST),
    .din   (bus.D_LE),
    .dsync (le_sync),
    .rise  (le_rise)
  );

  // Data line gets the same depth as D_CLK so a bit lines up with its edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dout_chain <= '0;
    end else begin
      dout_chain <= {dout_chain[SYNC_STAGES-2:0], bus.D_OUT};
    end
  end

  assign dout_sync  = dout_chain[SYNC_STAGES-1];
  assign frame_addr = shreg[2:0];
  assign frame_full = (bit_cnt == 6'(WORD_BITS));
  assign addr_ok    = (int'(frame_addr) < NUM_REGS);
  // A simultaneous D_CLK rise is dropped because LE takes priority.
  assign accept     = le_rise & frame_full & addr_ok;

  // Shift bits on D_CLK rise, classify the frame on LE rise.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shreg          <= '0;
      bit_cnt        <= '0;
      bus.WORD_VALID <= 1'b0;
      bus.WORD_DATA  <= '0;
      bus.WORD_ADDR  <= '0;
      bus.FRAME_ERR  <= 1'b0;
      bus.ADDR_ERR   <= 1'b0;
    end else begin
      bus.WORD_VALID <= 1'b0;
      bus.FRAME_ERR  <= 1'b0;
      bus.ADDR_ERR   <= 1'b0;
      if (le_rise) begin
        bit_cnt <= '0;
        if (!frame_full) begin
          bus.FRAME_ERR <= 1'b1;
        end else if (!addr_ok) begin
          bus.ADDR_ERR <= 1'b1;
        end else begin
          bus.WORD_VALID <= 1'b1;
          bus.WORD_DATA  <= shreg;
          bus.WORD_ADDR  <= frame_addr;
        end
      end else if (clk_rise && !le_sync) begin
        shreg <= {shreg[WORD_BITS-2:0], dout_sync};
        // Saturate so overlong frames can never wrap back to a valid count.
        if (bit_cnt != 6'd63) begin
          bit_cnt <= bit_cnt + 6'd1;
        end
      end
    end
  end

  // Shadow register bank written by accepted frames.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        bank[i] <= '0;
      end
    end else if (accept) begin
      bank[frame_addr] <= shreg;
    end
  end

  // Registered readback; a same-cycle write is seen one cycle later.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus.RD_DATA <= '0;
    end else if (int'(bus.RD_ADDR) < NUM_REGS) begin
      bus.RD_DATA <= bank[bus.RD_ADDR];
    end else begin
      bus.RD_DATA <= '0;
    end
  end

  // Write-order tracker: R5 always (re)starts, anything off-order aborts.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      seq_state    <= S_IDLE;
      bus.SEQ_ERR  <= 1'b0;
      bus.SEQ_DONE <= 1'b0;
    end else begin
      bus.SEQ_ERR  <= 1'b0;
      bus.SEQ_DONE <= 1'b0;
      if (accept) begin
        if (frame_addr == ADF_ADDR_R5) begin
          seq_state <= S_EXP4;
        end else if (seq_state != S_IDLE && frame_addr == seq_expect(seq_state)) begin
          seq_state <= seq_next(seq_state);
          if (seq_state == S_EXP0) begin
            bus.SEQ_DONE <= 1'b1;
          end
        end else begin
          bus.SEQ_ERR <= 1'b1;
          seq_state   <= S_IDLE;
        end
      end
    end
  end

  assign bus.DBG = '{
    seq_state: seq_state,
    bit_cnt:   bit_cnt,
    clk_s:     clk_sync,
    le_s:      le_sync,
    dout_s:    dout_sync
  };

endmodule

// File: tb/tb_adf4351_spi_rx.sv
// Bench for adf4351_spi_rx: directed programming scenarios followed by
// randomized frames, checked against a register-level reference model.
module tb_adf4351_spi_rx;
  import adf4351_pkg::*;

  logic CLK;
  logic RST;

  adf4351_spi_rx_if #(.WORD_BITS(32)) bus ();

  adf4351_spi_rx #(
    .SYNC_STAGES (2),
    .WORD_BITS   (32),
    .NUM_REGS    (6)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- bookkeeping ----------------
  int tests_run = 0;
  int failed    = 0;

  // Reference model state.
  logic [31:0] m_bank [6];
  logic [31:0] m_wdata;
  logic [2:0]  m_waddr;
  int          m_next;  // next register expected in the 5..0 run, -1 when none
  int exp_wv, exp_fe, exp_ae, exp_se, exp_sd;
  int act_wv, act_fe, act_ae, act_se, act_sd;

  logic [31:0] exp_q [$];
  logic [31:0] sb_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic seq_state_t exp_state(input int nxt);
    case (nxt)
      4:       return S_EXP4;
      3:       return S_EXP3;
      2:       return S_EXP2;
      1:       return S_EXP1;
      0:       return S_EXP0;
      default: return S_IDLE;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_bank[i] = '0;
    m_wdata = '0;
    m_waddr = '0;
    m_next  = -1;
    exp_q.delete();
  endtask

  task automatic model_frame(input logic [31:0] w, input int nbits);
    int a;
    a = int'(w[2:0]);
    if (nbits != 32) begin
      exp_fe++;
    end else if (a >= 6) begin
      exp_ae++;
    end else begin
      exp_wv++;
      m_bank[a] = w;
      m_wdata   = w;
      m_waddr   = w[2:0];
      exp_q.push_back(w);
      if (a == 5) begin
        m_next = 4;
      end else if (a == m_next) begin
        if (a == 0) begin
          exp_sd++;
          m_next = -1;
        end else begin
          m_next = a - 1;
        end
      end else begin
        exp_se++;
        m_next = -1;
      end
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge CLK) begin
    if (bus.WORD_VALID === 1'b1) begin
      act_wv++;
      tests_run++;
      if (exp_q.size() == 0) begin
        failed++;
        $error("FAIL sb_word: got %h expected none", bus.WORD_DATA);
      end else begin
        sb_exp = exp_q.pop_front();
        assert (bus.WORD_DATA === sb_exp) else begin
          failed++;
          $error("FAIL sb_word: got %h expected %h", bus.WORD_DATA, sb_exp);
        end
      end
    end
    if (bus.FRAME_ERR === 1'b1) act_fe++;
    if (bus.ADDR_ERR === 1'b1) act_ae++;
    if (bus.SEQ_ERR === 1'b1) act_se++;
    if (bus.SEQ_DONE === 1'b1) act_sd++;
    if ((bus.WORD_VALID | bus.FRAME_ERR | bus.ADDR_ERR | bus.SEQ_ERR | bus.SEQ_DONE) === 1'b1) begin
      tests_run++;
      assert ((int'(bus.WORD_VALID) + int'(bus.FRAME_ERR) + int'(bus.ADDR_ERR) <= 1) &&
              !(bus.SEQ_ERR && bus.SEQ_DONE) &&
              (!(bus.SEQ_ERR || bus.SEQ_DONE) || bus.WORD_VALID)) else begin
        failed++;
        $error("FAIL pulse_overlap: got wv%b fe%b ae%b se%b sd%b expected exclusive",
               bus.WORD_VALID, bus.FRAME_ERR, bus.ADDR_ERR, bus.SEQ_ERR, bus.SEQ_DONE);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_bit(input logic b);
    bus.D_OUT = b;
    wait_clk(2);
    bus.D_CLK = 1'b1;
    wait_clk(5);
    bus.D_CLK = 1'b0;
    wait_clk(3);
  endtask

  task automatic shift_bits(input logic [63:0] w, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic le_pulse();
    bus.D_LE = 1'b1;
    wait_clk(8);
    bus.D_LE = 1'b0;
    wait_clk(8);
  endtask

  task automatic send_frame(input logic [31:0] w, input int nbits);
    model_frame(w, nbits);
    shift_bits({32'h0, w}, nbits);
    le_pulse();
  endtask

  // 32 bits, then a 33rd D_CLK rise arriving together with LE.
  task automatic send_frame_simul(input logic [31:0] w);
    model_frame(w, 32);
    shift_bits({32'h0, w}, 32);
    bus.D_OUT = 1'b1;
    wait_clk(2);
    bus.D_CLK = 1'b1;
    bus.D_LE  = 1'b1;
    wait_clk(8);
    bus.D_CLK = 1'b0;
    bus.D_LE  = 1'b0;
    wait_clk(8);
  endtask

  task automatic after_frame();
    chk("word_valid_cnt", 32'(act_wv), 32'(exp_wv));
    chk("frame_err_cnt",  32'(act_fe), 32'(exp_fe));
    chk("addr_err_cnt",   32'(act_ae), 32'(exp_ae));
    chk("seq_err_cnt",    32'(act_se), 32'(exp_se));
    chk("seq_done_cnt",   32'(act_sd), 32'(exp_sd));
    chk("word_data",      bus.WORD_DATA, m_wdata);
    chk("word_addr",      32'(bus.WORD_ADDR), 32'(m_waddr));
    chk("seq_state",      32'(bus.DBG.seq_state), 32'(exp_state(m_next)));
    chk("bit_cnt_clear",  32'(bus.DBG.bit_cnt), 32'd0);
  endtask

  task automatic check_bank();
    for (int a = 0; a < 8; a++) begin
      bus.RD_ADDR = 3'(a);
      wait_clk(2);
      chk($sformatf("rd_r%0d", a), bus.RD_DATA, (a < 6) ? m_bank[a] : 32'h0);
    end
  endtask

  task automatic check_idle_outputs();
    chk("rst_word_valid", 32'(bus.WORD_VALID), 32'd0);
    chk("rst_word_data",  bus.WORD_DATA, 32'd0);
    chk("rst_word_addr",  32'(bus.WORD_ADDR), 32'd0);
    chk("rst_errs",       32'({bus.FRAME_ERR, bus.ADDR_ERR, bus.SEQ_ERR, bus.SEQ_DONE}), 32'd0);
    chk("rst_seq_state",  32'(bus.DBG.seq_state), 32'(S_IDLE));
    chk("rst_bit_cnt",    32'(bus.DBG.bit_cnt), 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] tmp;
    logic [31:0] w;
    int r, a, n;

    bus.D_CLK   = 1'b0;
    bus.D_OUT   = 1'b0;
    bus.D_LE    = 1'b0;
    bus.RD_ADDR = 3'd0;
    exp_wv = 0; exp_fe = 0; exp_ae = 0; exp_se = 0; exp_sd = 0;
    act_wv = 0; act_fe = 0; act_ae = 0; act_se = 0; act_sd = 0;
    model_reset();
    RST = 1'b0;
    wait_clk(5);
    RST = 1'b1;
    wait_clk(3);
    check_idle_outputs();
    chk("rst_rd_data", bus.RD_DATA, 32'd0);

    // Single R5 write.
    send_frame(ADF_DEF_R5, 32);
    after_frame();
    bus.RD_ADDR = 3'd5;
    wait_clk(2);
    chk("rd_r5_first", bus.RD_DATA, 32'h00400005);

    // Full in-order programming run.
    send_frame(ADF_DEF_R5, 32);
    send_frame(ADF_DEF_R4, 32);
    send_frame(ADF_DEF_R3, 32);
    send_frame(ADF_DEF_R2, 32);
    send_frame(ADF_DEF_R1, 32);
    send_frame(ADF_DEF_R0, 32);
    after_frame();
    check_bank();

    // Short and overlong frames are rejected.
    send_frame(32'h12345674, 31);
    after_frame();
    send_frame(32'hCAFE0003, 33);
    after_frame();
    check_bank();

    // Bad address mid-sequence leaves the tracker where it was.
    send_frame(ADF_DEF_R5, 32);
    send_frame(32'h00000006, 32);
    after_frame();

    // Out-of-order write, then a clean run.
    send_frame(ADF_DEF_R4, 32);
    send_frame(ADF_DEF_R2, 32);
    after_frame();
    send_frame(ADF_DEF_R5, 32);
    send_frame(ADF_DEF_R4, 32);
    send_frame(ADF_DEF_R3, 32);
    send_frame(ADF_DEF_R2, 32);
    send_frame(ADF_DEF_R1, 32);
    send_frame(ADF_DEF_R0, 32);
    after_frame();

    // Extra D_CLK edge coinciding with LE is discarded.
    send_frame_simul(32'hA5A5A5A5);
    after_frame();

    // Reset in the middle of a frame.
    shift_bits({32'h0, ADF_DEF_R3}, 16);
    RST = 1'b0;
    wait_clk(3);
    RST = 1'b1;
    model_reset();
    wait_clk(3);
    check_idle_outputs();
    send_frame(ADF_DEF_R1, 32);
    after_frame();
    check_bank();

    // Randomized frames.
    for (int k = 0; k < 40; k++) begin
      r   = $urandom_range(0, 9);
      tmp = $urandom();
      if (r < 3) begin
        a = (m_next < 0) ? 5 : m_next;
        w = {tmp[31:3], 3'(a)};
        send_frame(w, 32);
      end else if (r < 6) begin
        a = $urandom_range(0, 5);
        w = {tmp[31:3], 3'(a)};
        send_frame(w, 32);
      end else if (r < 8) begin
        a = $urandom_range(6, 7);
        w = {tmp[31:3], 3'(a)};
        send_frame(w, 32);
      end else begin
        n = $urandom_range(1, 40);
        if (n == 32) n = 31;
        send_frame(tmp, n);
      end
      after_frame();
      if (k % 10 == 9) check_bank();
    end

    chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
